// File: rtl/pe_seq_ctrl.sv
// Instruction sequencer feeding parallel_pe: turns iteration-count instructions into paired SRAM reads
// and aligned PE beats. Optional cycle counter is built only when PE_SEQ_PERF_EN is defined.
module pe_seq_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] neuron_base,
    input  logic [ADDR_W-1:0] weight_base,
    input  logic              inst_vld,
    input  logic [7:0]        inst_data,
    input  logic              inst_last,
    output logic              inst_rdy,
    output logic              n_rd_en,
    output logic [ADDR_W-1:0] n_rd_addr,
    input  logic [DATA_W-1:0] n_rd_data,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_rd_addr,
    input  logic [DATA_W-1:0] w_rd_data,
    output logic [DATA_W-1:0] pe_neuron,
    output logic [DATA_W-1:0] pe_weight,
    output logic              pe_vld,
    output logic [1:0]        pe_ctl,
    output logic              busy,
    output logic              done,
    output logic [31:0]       perf_cycles
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] n_ptr;
    logic [ADDR_W-1:0] w_ptr;
    logic [7:0]        iter;
    logic [7:0]        cnt_max;
    logic              last_f;
    logic              issuing;
    logic              at_end;
    logic              inst_acc;
    logic              start_acc;

    assign issuing   = (state == S_ISSUE);
    assign at_end    = issuing && (iter == cnt_max);
    assign start_acc = (state == S_IDLE) && start;

    // A non-final instruction may hand over to the next one in its last beat, giving zero bubble.
    assign inst_rdy  = (state == S_FETCH) || (at_end && !last_f);
    assign inst_acc  = inst_vld && inst_rdy;

    assign n_rd_en   = issuing;
    assign w_rd_en   = issuing;
    assign n_rd_addr = issuing ? n_ptr : '0;
    assign w_rd_addr = issuing ? w_ptr : '0;

    assign pe_neuron = n_rd_data;
    assign pe_weight = w_rd_data;

    // The done cycle already sits in IDLE, so it is folded back into busy here.
    assign busy      = (state != S_IDLE) || done;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (inst_vld) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (at_end) begin
                    if (last_f)         state_nxt = S_DRAIN;
                    else if (!inst_vld) state_nxt = S_FETCH;
                end
            end
            S_DRAIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_ptr <= '0;
            w_ptr <= '0;
        end else if (start_acc) begin
            n_ptr <= neuron_base;
            w_ptr <= weight_base;
        end else if (issuing) begin
            n_ptr <= n_ptr + 1'b1;
            w_ptr <= w_ptr + 1'b1;
        end
    end

    // inst_data of 0 wraps to cnt_max 255, i.e. a 256-beat instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter    <= '0;
            cnt_max <= '0;
            last_f  <= 1'b0;
        end else if (inst_acc) begin
            iter    <= '0;
            cnt_max <= inst_data - 8'd1;
            last_f  <= inst_last;
        end else if (issuing) begin
            iter    <= iter + 8'd1;
        end
    end

    // Read-to-data stage: controls registered once to line up with single-cycle SRAM data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_vld <= 1'b0;
            pe_ctl <= 2'b00;
            done   <= 1'b0;
        end else begin
            pe_vld <= issuing;
            pe_ctl <= issuing ? {iter == cnt_max, iter == 8'd0} : 2'b00;
            done   <= (state == S_DRAIN);
        end
    end

`ifdef PE_SEQ_PERF_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt <= '0;
        end else if (start_acc) begin
            perf_cnt <= '0;
        end else if (busy) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign perf_cycles = perf_cnt;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Scoreboard bench for pe_seq_ctrl: runs are expanded into expected PE beats (address-tagged data and
// first/last bits) from instruction counts; a negedge monitor pops and compares every pe_vld beat.
module tb_pe_seq_ctrl;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 512;
    localparam logic [31:0] NSALT = 32'h1234_5678;
    localparam logic [31:0] WSALT = 32'hCAFE_0F0F;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] neuron_base = '0;
    logic [ADDR_W-1:0] weight_base = '0;
    logic              inst_vld = 1'b0;
    logic [7:0]        inst_data = '0;
    logic              inst_last = 1'b0;
    logic              inst_rdy;
    logic              n_rd_en;
    logic [ADDR_W-1:0] n_rd_addr;
    logic [DATA_W-1:0] n_rd_data = '0;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [DATA_W-1:0] w_rd_data = '0;
    logic [DATA_W-1:0] pe_neuron;
    logic [DATA_W-1:0] pe_weight;
    logic              pe_vld;
    logic [1:0]        pe_ctl;
    logic              busy;
    logic              done;
    logic [31:0]       perf_cycles;

    pe_seq_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .neuron_base(neuron_base), .weight_base(weight_base),
        .inst_vld(inst_vld), .inst_data(inst_data), .inst_last(inst_last), .inst_rdy(inst_rdy),
        .n_rd_en(n_rd_en), .n_rd_addr(n_rd_addr), .n_rd_data(n_rd_data),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .pe_neuron(pe_neuron), .pe_weight(pe_weight), .pe_vld(pe_vld), .pe_ctl(pe_ctl),
        .busy(busy), .done(done), .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [ADDR_W-1:0] na;
        logic [ADDR_W-1:0] wa;
        logic [1:0]        ctl;
        bit                run_end;
    } beat_t;

    beat_t sb[$];
    beat_t mb;
    bit    exp_done = 0;
    bit    done_seen = 0;
    int    done_cyc = 0;
    int    prog_cnt[$];
    int    prog_gap[$];

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic [31:0] salt);
        logic [DATA_W-1:0] r;
        logic [31:0]       a32;
        a32 = 32'(a) * 32'h9E37_79B1;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = a32 ^ salt ^ 32'(i);
        return r;
    endfunction

    // Single-cycle-latency SRAMs whose contents are a function of the address.
    always @(posedge clk) begin
        if (n_rd_en) n_rd_data <= pat(n_rd_addr, NSALT);
        if (w_rd_en) w_rd_data <= pat(w_rd_addr, WSALT);
    end

    task automatic check(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        check({tag, "_inst_rdy"}, inst_rdy, 0);
        check({tag, "_n_rd_en"}, n_rd_en, 0);
        check({tag, "_w_rd_en"}, w_rd_en, 0);
        check({tag, "_n_rd_addr"}, n_rd_addr, 0);
        check({tag, "_w_rd_addr"}, w_rd_addr, 0);
        check({tag, "_pe_vld"}, pe_vld, 0);
        check({tag, "_pe_ctl"}, pe_ctl, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_perf"}, perf_cycles, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_done) begin
                check("done_pulse", done, 1);
                check("busy_in_done", busy, 1);
                done_cyc = cyc;
                done_seen = 1;
                exp_done = 0;
            end else if (done) begin
                check("done_spurious", done, 0);
            end
            if (pe_vld) begin
                if (sb.size() == 0) begin
                    check("pe_vld_unexpected", pe_vld, 0);
                end else begin
                    mb = sb.pop_front();
                    check("pe_ctl", pe_ctl, mb.ctl);
                    check("pe_neuron", pe_neuron, pat(mb.na, NSALT));
                    check("pe_weight", pe_weight, pat(mb.wa, WSALT));
                    check("busy_in_beat", busy, 1);
                    if (mb.run_end) exp_done = 1;
                end
            end
        end
    end

    // Enters and leaves just after a rising edge.
    task automatic run_prog(input logic [ADDR_W-1:0] nb, input logic [ADDR_W-1:0] wb);
        logic [ADDR_W-1:0] np;
        logic [ADDR_W-1:0] wp;
        int    s;
        int    total;
        int    pexp;
        bit    nogap;
        bit    ok;
        beat_t b;
        np = nb;
        wp = wb;
        total = 0;
        nogap = 1;
        done_seen = 0;
        neuron_base = nb;
        weight_base = wb;
        start = 1;
        s = cyc;
        @(posedge clk); #1;
        start = 0;
        neuron_base = ADDR_W'($urandom);
        weight_base = ADDR_W'($urandom);
        for (int i = 0; i < prog_cnt.size(); i++) begin
            if (prog_gap[i] > 0) begin
                nogap = 0;
                inst_vld = 0;
                repeat (prog_gap[i]) @(posedge clk);
                #1;
            end
            inst_vld = 1;
            inst_data = 8'(prog_cnt[i]);
            inst_last = (i == prog_cnt.size() - 1);
            for (int j = 0; j < prog_cnt[i]; j++) begin
                b.na = np;
                b.wa = wp;
                b.ctl = {j == prog_cnt[i] - 1, j == 0};
                b.run_end = inst_last && (j == prog_cnt[i] - 1);
                sb.push_back(b);
                np = np + 1'b1;
                wp = wp + 1'b1;
            end
            total += prog_cnt[i];
            ok = 0;
            for (int k = 0; k < 1000; k++) begin
                @(negedge clk);
                if (inst_rdy) begin
                    ok = 1;
                    break;
                end
            end
            @(posedge clk); #1;
            if (!ok) begin
                check("inst_handshake_timeout", 0, 1);
                inst_vld = 0;
                return;
            end
        end
        inst_vld = 0;
        inst_data = 8'($urandom);
        inst_last = 1'($urandom);
        ok = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk); #1;
            if (done_seen) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            check("done_timeout", 0, 1);
        end else begin
            if (nogap) check("run_latency", done_cyc - s, total + 3);
            check("queue_drained", sb.size(), 0);
        end
        @(posedge clk); #1;
        check("busy_after_done", busy, 0);
`ifdef PE_SEQ_PERF_EN
        pexp = done_cyc - s;
`else
        pexp = 0;
`endif
        check("perf_cycles", perf_cycles, pexp);
    endtask

    task automatic set_prog1(input int c, input int g);
        prog_cnt.delete();
        prog_gap.delete();
        prog_cnt.push_back(c);
        prog_gap.push_back(g);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b;
        repeat (2) @(posedge clk);
        #2;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1;

        inst_vld = 1;
        inst_data = 8'd3;
        repeat (2) @(posedge clk);
        #1;
        check("idle_ignores_inst_rdy", inst_rdy, 0);
        check("idle_ignores_busy", busy, 0);
        check("idle_ignores_rd_en", n_rd_en, 0);
        inst_vld = 0;

        set_prog1(3, 0);
        run_prog(16'h0000, 16'h0100);

        prog_cnt = '{2, 1, 4};
        prog_gap = '{0, 0, 0};
        run_prog(16'h0000, 16'h0200);

        set_prog1(256, 0);
        run_prog(16'h0010, 16'h0300);

        prog_cnt = '{2, 2};
        prog_gap = '{0, 5};
        run_prog(16'h0020, 16'h0400);

        set_prog1(4, 0);
        run_prog(16'h0030, 16'h0500);

        // Mid-run start must be ignored, then reset discards the partial run.
        done_seen = 0;
        neuron_base = 16'h0040;
        weight_base = 16'h0080;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        inst_vld = 1;
        inst_data = 8'd10;
        inst_last = 0;
        for (int j = 0; j < 10; j++) begin
            b.na = 16'h0040 + 16'(j);
            b.wa = 16'h0080 + 16'(j);
            b.ctl = {j == 9, j == 0};
            b.run_end = 0;
            sb.push_back(b);
        end
        @(posedge clk); #1;
        inst_vld = 0;
        repeat (3) @(posedge clk);
        #1;
        neuron_base = 16'h0999;
        weight_base = 16'h0AAA;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 0;
        sb.delete();
        exp_done = 0;
        #1;
        chk_all_zero("rst_mid");
        repeat (3) begin
            @(negedge clk); #1;
            check("rst_hold_n_rd_en", n_rd_en, 0);
            check("rst_hold_pe_vld", pe_vld, 0);
        end
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        check("post_rst_idle_rd_en", n_rd_en, 0);

        set_prog1(3, 0);
        run_prog(16'h0555, 16'h0777);

        for (int r = 0; r < 10; r++) begin
            int n;
            logic [ADDR_W-1:0] nb;
            logic [ADDR_W-1:0] wb;
            n = $urandom_range(1, 4);
            prog_cnt.delete();
            prog_gap.delete();
            for (int i = 0; i < n; i++) begin
                prog_cnt.push_back(($urandom_range(0, 15) == 0) ? 256 : $urandom_range(1, 9));
                prog_gap.push_back(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
            end
            nb = ($urandom_range(0, 2) == 0) ? 16'hFFFC : ADDR_W'($urandom);
            wb = ADDR_W'($urandom);
            run_prog(nb, wb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
